// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared constants and types for the scrolling VGA pattern generator.
//   - Default 640x480@60 timing constants (pixels / lines).
//   - pattern_mode_e : pattern selected by the 2-bit mode input.
//   - btn_t          : button bundle, packed in the same order as the
//                      raw buttons port {up, down, left, right}.
//   - wrap_step()    : modular +/- step used for the scroll offsets.
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  typedef enum logic [1:0] {
    CHECKER = 2'd0,
    BARS    = 2'd1,
    GRID    = 2'd2,
    SOLID   = 2'd3
  } pattern_mode_e;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } btn_t;

  // One scroll step on an axis. Opposing directions cancel. Assumes
  // step < modulus, so a single add/subtract of the modulus wraps.
  function automatic int wrap_step(int val, int step, int modulus,
                                   logic inc, logic dec);
    int r;
    r = val;
    if (inc && !dec) begin
      r = val + step;
      if (r >= modulus) r = r - modulus;
    end else if (dec && !inc) begin
      r = val - step;
      if (r < 0) r = r + modulus;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_debounce.sv
// ---------------------------------------------------------------------------
// vga_debounce
//   Two-flop synchroniser followed by a stability counter. The output level
//   follows the synchronised input only after DEBOUNCE_CYC consecutive clks
//   at the new level; any return to the current output level restarts the
//   count, so short glitches never reach dout.
//   Ports: clk, rst (async, active-high), din (raw, asynchronous),
//          dout (debounced level, 0 in reset).
// ---------------------------------------------------------------------------
module vga_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      cnt    <= '0;
      dout   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      if (sync_q[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        dout <= sync_q[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_scroll_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_scroll_pattern_gen
//   VGA timing generator with a scrollable test pattern (checker, bars,
//   grid, solid). Four debounced buttons scroll the pattern by SCROLL_STEP
//   pixels per frame while held; offsets and pattern mode change only at
//   frame start so a frame is never torn.
//   Ports:
//     clk, rst              system clock, async active-high reset
//     buttons[3:0]          raw {up, down, left, right}, asynchronous
//     mode[1:0]             pattern select, sampled at frame start
//     red/green/blue        pixel colour, registered, zero outside active
//     hsync/vsync           syncs, registered alongside the colour
//     frame_start           high during the pixel-enable of pixel (0,0)
//     x_off/y_off           scroll offsets in use for the current frame
// ---------------------------------------------------------------------------
module vga_scroll_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_D,
  parameter int H_FP         = H_FP_D,
  parameter int H_SYNC       = H_SYNC_D,
  parameter int H_BP         = H_BP_D,
  parameter int V_ACTIVE     = V_ACTIVE_D,
  parameter int V_FP         = V_FP_D,
  parameter int V_SYNC       = V_SYNC_D,
  parameter int V_BP         = V_BP_D,
  parameter bit SYNC_POL     = 1'b0,
  parameter int CLK_DIV      = 4,
  parameter int CELL_LOG2    = 4,
  parameter int COLOR_W      = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SCROLL_STEP  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    buttons,
  input  logic [1:0]                    mode,
  output logic [COLOR_W-1:0]            red,
  output logic [COLOR_W-1:0]            green,
  output logic [COLOR_W-1:0]            blue,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          frame_start,
  output logic [$clog2(H_ACTIVE)-1:0]   x_off,
  output logic [$clog2(V_ACTIVE)-1:0]   y_off
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [XW:0]   HA_X       = (XW+1)'(H_ACTIVE);
  localparam logic [YW:0]   VA_Y       = (YW+1)'(V_ACTIVE);
  localparam logic [XW-1:0] X_CELL_BIT = XW'(1 << CELL_LOG2);
  localparam logic [YW-1:0] Y_CELL_BIT = YW'(1 << CELL_LOG2);
  localparam logic [XW-1:0] X_CELL_MSK = XW'((1 << CELL_LOG2) - 1);
  localparam logic [YW-1:0] Y_CELL_MSK = YW'((1 << CELL_LOG2) - 1);

  // ---- pixel enable: registered so it is low throughout reset ----------
  logic [DW-1:0] div_cnt;
  logic          pix_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else if (div_cnt == DW'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      pix_en  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      pix_en  <= 1'b0;
    end
  end

  // ---- raster counters --------------------------------------------------
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);

  // ---- button debounce --------------------------------------------------
  logic [3:0] btn_db_bits;
  btn_t       btn_db;

  for (genvar i = 0; i < 4; i++) begin : g_db
    vga_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk  (clk),
      .rst  (rst),
      .din  (buttons[i]),
      .dout (btn_db_bits[i])
    );
  end

  assign btn_db = btn_t'(btn_db_bits);

  // ---- per-frame state: offsets and latched mode -------------------------
  // The first frame after reset always shows zero offsets: 'started' holds
  // off the scroll step until one frame start has gone by.
  logic          started;
  pattern_mode_e mode_q, mode_use;
  logic [XW-1:0] x_next, x_use;
  logic [YW-1:0] y_next, y_use;
  logic          scroll_upd;

  assign x_next = XW'(wrap_step(int'(x_off), SCROLL_STEP, H_ACTIVE,
                                btn_db.right, btn_db.left));
  assign y_next = YW'(wrap_step(int'(y_off), SCROLL_STEP, V_ACTIVE,
                                btn_db.down, btn_db.up));

  assign scroll_upd = frame_start && started;

  // Pixel (0,0) is computed in the same cycle the new frame state is
  // loaded, so it uses the incoming values rather than the stale registers.
  assign x_use    = scroll_upd  ? x_next : x_off;
  assign y_use    = scroll_upd  ? y_next : y_off;
  assign mode_use = frame_start ? pattern_mode_e'(mode) : mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started <= 1'b0;
      mode_q  <= CHECKER;
      x_off   <= '0;
      y_off   <= '0;
    end else if (frame_start) begin
      started <= 1'b1;
      mode_q  <= mode_use;
      x_off   <= x_use;
      y_off   <= y_use;
    end
  end

  // ---- pattern ----------------------------------------------------------
  logic          active;
  logic [XW:0]   xsum;
  logic [YW:0]   ysum;
  logic [XW-1:0] xs;
  logic [YW-1:0] ys;
  logic          x_cell, y_cell, x_edge, y_edge;
  logic          pix_white;
  logic          h_sync_win, v_sync_win;

  assign active = ({1'b0, h_cnt} < (HW+1)'(H_ACTIVE)) &&
                  ({1'b0, v_cnt} < (VW+1)'(V_ACTIVE));

  // Low counter bits are only meaningful inside the active area, where
  // h < H_ACTIVE; outside it the colour is forced to black anyway.
  assign xsum = {1'b0, h_cnt[XW-1:0]} + {1'b0, x_use};
  assign ysum = {1'b0, v_cnt[YW-1:0]} + {1'b0, y_use};
  assign xs   = (xsum >= HA_X) ? XW'(xsum - HA_X) : xsum[XW-1:0];
  assign ys   = (ysum >= VA_Y) ? YW'(ysum - VA_Y) : ysum[YW-1:0];

  assign x_cell = |(xs & X_CELL_BIT);
  assign y_cell = |(ys & Y_CELL_BIT);
  assign x_edge = ((xs & X_CELL_MSK) == '0);
  assign y_edge = ((ys & Y_CELL_MSK) == '0);

  always_comb begin
    pix_white = 1'b0;
    case (mode_use)
      CHECKER: pix_white = x_cell ^ y_cell;
      BARS:    pix_white = x_cell;
      GRID:    pix_white = x_edge | y_edge;
      SOLID:   pix_white = 1'b1;
      default: pix_white = 1'b0;
    endcase
    if (!active) pix_white = 1'b0;
  end

  assign h_sync_win = ({1'b0, h_cnt} >= (HW+1)'(H_ACTIVE + H_FP)) &&
                      ({1'b0, h_cnt} <  (HW+1)'(H_ACTIVE + H_FP + H_SYNC));
  assign v_sync_win = ({1'b0, v_cnt} >= (VW+1)'(V_ACTIVE + V_FP)) &&
                      ({1'b0, v_cnt} <  (VW+1)'(V_ACTIVE + V_FP + V_SYNC));

  // ---- output registers: colour and sync share one pixel of latency ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
    end else if (pix_en) begin
      red   <= {COLOR_W{pix_white}};
      green <= {COLOR_W{pix_white}};
      blue  <= {COLOR_W{pix_white}};
      hsync <= h_sync_win ? SYNC_POL : ~SYNC_POL;
      vsync <= v_sync_win ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_scroll_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_scroll_pattern_gen
//   Reduced raster (50x40 active) so a dozen frames fit a short run. A
//   reference model derives every pixel from its linear index with plain
//   division/modulo arithmetic and pushes the expected outputs into a
//   scoreboard queue; a separate monitor pops and compares on the
//   following falling edge. Stimulus changes mid-frame; the model applies
//   button/mode effects at the next frame start.
// ---------------------------------------------------------------------------
module tb_vga_scroll_pattern_gen;

  localparam int HA = 50, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 40, VFP = 1, VS = 2, VBP = 1;
  localparam int CD = 2, CL2 = 4, CW = 4, DB = 4, STEP = 3;
  localparam bit SP = 1'b0;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int FCLK = FT * CD;
  localparam int CELL = 1 << CL2;
  localparam int XW = $clog2(HA);
  localparam int YW = $clog2(VA);
  localparam int PW = 3 * CW + 2 + XW + YW;

  logic          clk, rst;
  logic [3:0]    buttons;
  logic [1:0]    mode;
  logic [CW-1:0] red, green, blue;
  logic          hsync, vsync, frame_start;
  logic [XW-1:0] x_off;
  logic [YW-1:0] y_off;

  vga_scroll_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(SP), .CLK_DIV(CD), .CELL_LOG2(CL2), .COLOR_W(CW),
    .DEBOUNCE_CYC(DB), .SCROLL_STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .mode(mode),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .x_off(x_off), .y_off(y_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int             e;          // clk edges since reset release
  int             errors, checks;
  logic [PW-1:0]  sb_q[$];
  logic [3:0]     btn_lvl;    // intended (debounced) button level
  int             mdl_xo, mdl_yo, mdl_md;

  // Expected outputs of linear pixel p (counted from reset release).
  task automatic model_pixel(input int p);
    int q, f, h, v, xs, ys;
    bit act, wh, hs, vs;
    logic [CW-1:0] c;
    q = p % FT;
    f = p / FT;
    if (q == 0) begin
      if (f > 0) begin
        if (btn_lvl[0] && !btn_lvl[1]) mdl_xo = (mdl_xo + STEP) % HA;
        else if (btn_lvl[1] && !btn_lvl[0]) mdl_xo = (mdl_xo - STEP + HA) % HA;
        if (btn_lvl[2] && !btn_lvl[3]) mdl_yo = (mdl_yo + STEP) % VA;
        else if (btn_lvl[3] && !btn_lvl[2]) mdl_yo = (mdl_yo - STEP + VA) % VA;
      end
      mdl_md = int'(mode);
    end
    h = q % HT;
    v = q / HT;
    act = (h < HA) && (v < VA);
    xs = (h + mdl_xo) % HA;
    ys = (v + mdl_yo) % VA;
    case (mdl_md)
      0:       wh = (((xs / CELL) + (ys / CELL)) % 2) == 1;
      1:       wh = ((xs / CELL) % 2) == 1;
      2:       wh = ((xs % CELL) == 0) || ((ys % CELL) == 0);
      default: wh = 1'b1;
    endcase
    wh = wh && act;
    hs = (h >= HA + HFP && h < HA + HFP + HS) ? SP : !SP;
    vs = (v >= VA + VFP && v < VA + VFP + VS) ? SP : !SP;
    c = wh ? {CW{1'b1}} : {CW{1'b0}};
    sb_q.push_back({c, c, c, hs, vs, XW'(mdl_xo), YW'(mdl_yo)});
  endtask

  // Model: pixel p is registered on edge CD*(p+1)+1 after reset release.
  initial begin
    e = 0; mdl_xo = 0; mdl_yo = 0; mdl_md = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        e = 0; mdl_xo = 0; mdl_yo = 0; mdl_md = 0;
      end else begin
        e++;
        if (e >= CD + 1 && (e - 1) % CD == 0) model_pixel((e - 1) / CD - 1);
      end
    end
  end

  // Monitor
  initial begin
    logic [PW-1:0] exp_v, got_v;
    bit exp_fs;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (e >= CD && e % CD == 0) begin
          exp_fs = (((e / CD) - 1) % FT) == 0;
          checks++;
          if (frame_start !== exp_fs) begin
            errors++;
            $display("FAIL frame_start e=%0d got=%b exp=%b", e, frame_start, exp_fs);
          end
        end
        if (sb_q.size() > 0) begin
          exp_v = sb_q.pop_front();
          got_v = {red, green, blue, hsync, vsync, x_off, y_off};
          checks++;
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL pixel e=%0d p=%0d got=%h exp=%h", e, (e - 1) / CD - 1, got_v, exp_v);
          end
        end
      end
    end
  end

  task automatic check_reset(input string name);
    logic [PW:0] got_v, exp_v;
    got_v = {red, green, blue, hsync, vsync, frame_start, x_off, y_off};
    exp_v = {{(3*CW){1'b0}}, !SP, !SP, 1'b0, {XW{1'b0}}, {YW{1'b0}}};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got_v, exp_v);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    btn_lvl = b;
    buttons = b;
  endtask

  // Wait until the middle of frame k (frames counted from reset release).
  task automatic goto_mid(input int k);
    int target, n;
    target = CD + 1 + k * FCLK + FCLK / 2;
    n = 0;
    while (e < target) begin
      @(negedge clk);
      n++;
      if (n > 2 * FCLK + 100) begin
        checks++;
        errors++;
        $display("FAIL goto_mid k=%0d e=%0d target=%0d", k, e, target);
        break;
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; buttons = 4'b0; btn_lvl = 4'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    check_reset("reset_init");
    rst = 1'b0;

    goto_mid(0); set_btn(4'b0010);               // left: 0 -> 47
    goto_mid(1); set_btn(4'b0001);               // right: 47 -> 0
    goto_mid(2); set_btn(4'b1101);               // up+down cancel, right +3
    goto_mid(3); set_btn(4'b1000); mode = 2'd2;  // up: 0 -> 37, grid next
    goto_mid(4); set_btn(4'b0000); mode = 2'd0;
    buttons = 4'b0001;                           // 2-clk glitch on right
    repeat (2) @(negedge clk);
    buttons = 4'b0000;
    for (int k = 5; k < 9; k++) begin
      goto_mid(k);
      set_btn(4'($urandom_range(0, 15)));
      mode = 2'($urandom_range(0, 3));
    end
    goto_mid(9); set_btn(4'($urandom_range(0, 15))); mode = 2'd3;

    // Asynchronous reset in the middle of an active line of a solid frame.
    goto_mid(10);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("reset_mid");
    sb_q.delete();
    set_btn(4'b0001);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    goto_mid(1);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
